// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART blocks.
// Holds the receiver FSM state encoding, the parity mode constants and
// the parity check used when the parity bit is sampled.
package uart_pkg;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_EVEN = 2'd1;
    localparam logic [1:0] PARITY_ODD  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    // Data is zero-extended to 9 bits; the padding zeros do not change the XOR.
    function automatic logic parity_error(input logic [1:0] mode,
                                          input logic [8:0] data,
                                          input logic       pbit);
        case (mode)
            PARITY_EVEN: return ^{data, pbit};
            PARITY_ODD:  return ~^{data, pbit};
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous level input, presets to 1 (idle line).
// Latency: STAGES clk cycles from d to q.
// Backpressure: none, free-running every cycle.
// Ports: clk/rst (async active-high), d async input, q synchronised output.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with ready/valid output register and error flags.
// Latency: rx_valid rises the cycle after the final stop-bit sample.
// Backpressure: one held word; a frame completing while it is unaccepted is dropped and sets overrun_err.
// Ports: clk, rst (async active-high), rx serial in; rx_data/rx_valid/rx_ready output handshake;
//        parity_err/frame_err describe the held word; overrun_err sticky, cleared by clr_err; busy = not IDLE.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 5210,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    input  logic                 clr_err,
    output logic                 busy
);

    import uart_pkg::*;

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = 4;
    localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [1:0]    PMODE     = 2'(PARITY_MODE);

    logic                 rx_s;
    logic                 rx_prev;
    rx_state_t            state, state_nxt;
    logic [TW-1:0]        tick;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err_q;
    logic                 frm_err_q;
    logic                 expire;
    logic                 deliver;
    logic                 frm_err_now;

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // The tick counter counts up from CLKS_PER_BIT/2 after the falling edge and
    // wraps at CLKS_PER_BIT-1; each wrap is one sample point, so samples stay
    // exactly one bit period apart.
    assign expire      = (tick == TICK_LAST);
    // Include the stop sample currently being taken.
    assign frm_err_now = frm_err_q | ~rx_s;
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        deliver   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_prev && !rx_s) state_nxt = ST_START;
            end
            ST_START: begin
                if (expire) state_nxt = rx_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (expire && bit_cnt == DATA_LAST)
                    state_nxt = (PMODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (expire) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (expire && bit_cnt == STOP_LAST) begin
                    deliver   = 1'b1;
                    // A low final stop sample is itself a frame error, so a
                    // still-low line means a break: wait for it to go high.
                    state_nxt = rx_s ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rx_s) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_prev   <= 1'b1;
            tick      <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            rx_prev <= rx_s;
            if (state == ST_IDLE) begin
                tick      <= TICK_HALF;
                bit_cnt   <= '0;
                par_err_q <= 1'b0;
                frm_err_q <= 1'b0;
            end else begin
                tick <= expire ? '0 : tick + 1'b1;
                if (expire) begin
                    case (state)
                        ST_DATA: begin
                            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                            bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + 1'b1;
                        end
                        ST_PARITY: par_err_q <= parity_error(PMODE, 9'(shreg), rx_s);
                        ST_STOP: begin
                            if (!rx_s) frm_err_q <= 1'b1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Output register: a new frame loads when the slot is empty or is being
    // emptied on this same edge; otherwise it is dropped as an overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (deliver && (!rx_valid || rx_ready)) begin
                rx_data    <= shreg;
                parity_err <= par_err_q;
                frame_err  <= frm_err_now;
                rx_valid   <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (deliver && rx_valid && !rx_ready) begin
                overrun_err <= 1'b1;
            end else if (clr_err) begin
                overrun_err <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver for the risc_v_top platform. It generalises the current fixed 8-bit, even-parity serial input path with the following configurable features:
- data width
- parity mode
- stop-bit count
- oversampling divisor

It delivers each received frame through a ready/valid output register and reports per-frame error flags, plus a sticky overrun flag. It sits between the rx pin and the memory-mapped UART register block.

Parameters:
CLKS_PER_BIT, 5210, clk cycles per bit period (≥4); 5210 = 10420 ns bit time at 2 ns clk
DATA_BITS, 8, data bits per frame (5–9), LSB first
PARITY_MODE, 1, 0 none, 1 even, 2 odd
STOP_BITS, 1, 1 or 2
SYNC_STAGES, 2, rx synchroniser flops (≥2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
rx  in  1  serial input, idle high, asynchronous to clk
rx_data  out  DATA_BITS  received data word
rx_valid  out  1  rx_data / parity_err / frame_err valid
rx_ready  in  1  consumer accepts the word on rx_valid && rx_ready
parity_err  out  1  parity mismatch for the held word
frame_err  out  1  a stop bit sampled low for the held word
overrun_err  out  1  sticky: a completed frame was dropped
clr_err  in  1  clears overrun_err (synchronous pulse)
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0; FSM in IDLE; synchroniser flops preset to 1; counters 0.
- Synchroniser: rx passes through SYNC_STAGES flops to give rx_s. All FSM logic uses rx_s only.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK. One bit counter and one CLKS_PER_BIT-range tick counter.
- IDLE: a falling edge on rx_s (previous 1, current 0) moves to START and loads the tick counter with CLKS_PER_BIT/2 (integer division).
- START: at tick expiry, sample rx_s.
  - 1: false start, go to IDLE, no output.
  - 0: go to DATA, tick counter reloads CLKS_PER_BIT.
- DATA: sample at each tick expiry into the shift register, LSB first. After DATA_BITS samples, go to PARITY if PARITY_MODE≠0, else to STOP.
- PARITY: sample one bit and compute the error.
  - Even: parity_err = ^{data, pbit}.
  - Odd: parity_err = ~^{data, pbit}.
  - PARITY_MODE = 0: parity_err is always 0.
- STOP: sample STOP_BITS bits; any low sample sets frame_err. After the last sample, deliver the frame.
  - If frame_err is set and rx_s is 0: go to BREAK.
  - Otherwise: go to IDLE.
- BREAK: wait for rx_s = 1, then go to IDLE. A falling edge is not accepted until rx_s has been seen high.
- Sample timing: the k-th sample after START (k = 1…) is taken CLKS_PER_BIT/2 + k·CLKS_PER_BIT cycles after the falling edge of rx_s.
- Latency: rx_valid rises on the cycle after the final stop sample.
- Delivery: on delivery, the output register loads rx_data, parity_err and frame_err, and sets rx_valid. All are held stable until the handshake.
- Handshake: rx_valid && rx_ready clears rx_valid on the next edge. rx_data keeps its value.
- Overrun: on delivery while rx_valid=1 and rx_ready=0, the new frame is dropped, the held word is unchanged, and overrun_err is set. If delivery coincides with a handshake, the new word is loaded and there is no overrun.
- clr_err: clears overrun_err. If it coincides with a new overrun, the set wins.
- Reset mid-frame: aborts immediately to IDLE and clears the output register.
- Tick counter: wraps CLKS_PER_BIT-1 → 0 with no drift. Width is $clog2(CLKS_PER_BIT).

Decomposition:
- Package uart_pkg: FSM state enum, PARITY_NONE/EVEN/ODD constants, and the parity function.
- One sub-module, uart_sync: a SYNC_STAGES-deep synchroniser with preset-to-1 reset, reusable by uart_tx_param's cts input.

Test Plan:
1. CLKS_PER_BIT=16, even parity. Send 0x09 with parity 0 and stop 1 → rx_valid=1, rx_data=0x09, parity_err=0, frame_err=0. rx_valid rises exactly 8+10·16+1 cycles after rx_s falls.
2. Same configuration. Send 0x09 with parity 1 → rx_data=0x09, parity_err=1. With PARITY_MODE=2, the same frame gives parity_err=0.
3. Stop bit held low for 3 bit times, then high → frame_err=1 and busy stays high until rx_s returns to 1. A following 0xA5 frame is received correctly.
4. Glitch: rx low for 4 cycles (less than CLKS_PER_BIT/2) → no rx_valid, FSM back in IDLE, busy low.
5. rx_ready=0. Send 0x11 then 0x22 → rx_data stays 0x11 and overrun_err=1. Raise rx_ready, then pulse clr_err → rx_valid=0 and overrun_err=0.
6. DATA_BITS=7, PARITY_MODE=0, STOP_BITS=2. Send 0x55, then assert rst mid-frame → after the first frame rx_data=0x55; after reset all outputs are 0 and no valid appears.
